keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed 7-segment display driver: scans a 4x4 active-low button matrix (elevator floor-call / cabin panel) by rotating an active-low column select.
- Reads the row lines, debounces over whole scan frames, and reports one key code with a single-cycle valid pulse per press.
- Sits between the panel pins and the elevator control FSM.

Parameters:
DWELL, 4096, clock cycles each column is driven before rotating (>=2)
DEBOUNCE_SCANS, 4, consecutive identical scan frames needed to accept a press or a release (>=1)
REPEAT_SCANS, 32, frames between auto-repeat pulses (used only with KEY_REPEAT_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rows  in  4  matrix row inputs, active-low, asynchronous to clk, pulled up externally
col_sel  out  4  column drive, active-low, exactly one bit low
key_code  out  4  accepted key, code = col_index*4 + row_index
key_valid  out  1  one-cycle pulse when a press is accepted
key_held  out  1  high from acceptance until release is accepted

Behaviour:
- Reset (async, any time, including mid-debounce):
  - col_sel=4'b1110; key_code=0, key_valid=0, key_held=0.
  - Dwell counter=0, synchronizer=4'b1111, FSM=IDLE, frame accumulators cleared.
- rows pass through a 2-FF synchronizer before any use.
- Column rotation:
  - Dwell counter 0..DWELL-1; col_sel advances 1110->1101->1011->0111->1110 on the cycle after the counter reaches DWELL-1.
  - Row sample is taken from the synchronized rows on the counter==DWELL-1 cycle, for the column currently driven.
- Frame: 4 consecutive column samples (col 0..3). The accumulator counts pressed keys (every row bit at 0 counts) and records the code of the last pressed key.
- Frame result, evaluated on the col-3 sample cycle:
  - NONE (0 keys)
  - SINGLE(K) (exactly 1 key)
  - MULTI (>1 keys, treated as no valid key)
- FSM, updated once per frame end; cnt is the frame counter:
  - IDLE: SINGLE(K) -> cand=K, cnt=1; go to PRESSED directly if DEBOUNCE_SCANS==1, else DEBOUNCE. Otherwise stay.
  - DEBOUNCE:
    - SINGLE(cand) -> cnt+1; on reaching DEBOUNCE_SCANS go to PRESSED.
    - SINGLE(other K) -> cand=K, cnt=1.
    - NONE/MULTI -> IDLE.
  - Entry to PRESSED (from IDLE or DEBOUNCE): key_code<=cand, key_held<=1, key_valid=1 for exactly the next clock cycle.
  - PRESSED: SINGLE(key_code) -> stay. Any other result -> RELEASE, cnt=1 (go straight to IDLE if DEBOUNCE_SCANS==1).
  - RELEASE:
    - Non-key_code result -> cnt+1; on reaching DEBOUNCE_SCANS go to IDLE and key_held<=0.
    - SINGLE(key_code) -> PRESSED, no new pulse.
    - key_held stays 1 throughout RELEASE.
- key_code holds its last accepted value after release, until the next acceptance or reset.
- Latency: key_valid rises 1 cycle after the frame-end sample of the DEBOUNCE_SCANS-th qualifying frame.
- Worst case from the pin edge: 2 (sync) + (DEBOUNCE_SCANS+1)*4*DWELL + 1 cycles.
- Counters saturate and never wrap inside a state.
- A key change mid-frame is seen only by columns sampled after the change. Mixed frames follow the rules above.

Optional Feature:
KEY_REPEAT_EN:
- Defined: in PRESSED, a frame counter increments on each SINGLE(key_code) frame. On reaching REPEAT_SCANS, key_valid pulses one cycle again (key_code unchanged) and the counter restarts from 0.
- The counter clears on entering PRESSED from DEBOUNCE or RELEASE.
- Undefined: exactly one key_valid pulse per accepted press; no repeat logic is built.

Test Plan:
- Run with DWELL=4, DEBOUNCE_SCANS=3 (frame = 16 cycles) unless stated.
- Reset: assert rst mid-scan -> col_sel=1110 immediately, all outputs 0. After release, col_sel=1101 exactly 4 cycles later; full rotation period 16 cycles.
- Clean press: hold rows=4'b1101 whenever col_sel=1011 -> after 3 full frames key_code=9, key_valid high exactly 1 cycle, key_held=1. Release -> key_held=0 after 3 key-free frames, no pulse.
- Bounce: key 9 present 2 frames, absent 1, present 3 -> exactly one key_valid pulse, at the end of the 3rd frame of the final run. Release glitch of 1 frame while held -> key_held stays 1, no new pulse.
- Multi-key: keys 0 and 6 held together -> no key_valid. Drop key 0 -> key_code=6 with a pulse after 3 frames.
- Key change: key 3 for 2 frames, then key 12 for 3 frames -> single pulse with key_code=12. Assert rst during DEBOUNCE -> no pulse; debounce restarts from frame 1 after release.
- KEY_REPEAT_EN, REPEAT_SCANS=2: hold key 5 -> first pulse after 3 frames, then a pulse every 2 frames while held. Without the macro, only one pulse.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: rotating column drive, frame-based debounce, one valid pulse per press.
// Optional build macro KEY_REPEAT_EN adds auto-repeat pulses while a key stays held.
module keypad_scanner #(
    parameter int DWELL          = 4096,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rows,
    output logic [3:0] col_sel,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(DWELL);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    if (DWELL < 2 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_bad_params
        $error("keypad_scanner: DWELL>=2, DEBOUNCE_SCANS>=1, REPEAT_SCANS>=1 required");
    end

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    logic [3:0]    rows_meta_q, rows_sync_q;
    logic [DW-1:0] dwell_q;
    logic [1:0]    col_q;
    logic [1:0]    acc_num_q;
    logic [3:0]    acc_code_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_held_q, key_held_d;
    logic          key_valid_q, key_valid_d;

    logic [1:0] scan_num;
    logic [3:0] scan_code;
    logic       sample, frame_end, is_single, match_held, match_cand;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_meta_q <= 4'b1111;
            rows_sync_q <= 4'b1111;
            dwell_q     <= '0;
            col_q       <= 2'd0;
            acc_num_q   <= 2'd0;
            acc_code_q  <= 4'd0;
        end else begin
            rows_meta_q <= rows;
            rows_sync_q <= rows_meta_q;
            if (sample) begin
                dwell_q <= '0;
                col_q   <= col_q + 2'd1;
                if (frame_end) begin
                    acc_num_q  <= 2'd0;
                    acc_code_q <= 4'd0;
                end else begin
                    acc_num_q  <= scan_num;
                    acc_code_q <= scan_code;
                end
            end else begin
                dwell_q <= dwell_q + DW'(1);
            end
        end
    end

    // Key count saturates at 2: the FSM only distinguishes none, single and multi.
    always_comb begin
        scan_num  = acc_num_q;
        scan_code = acc_code_q;
        for (int r = 0; r < 4; r++) begin
            if (!rows_sync_q[r]) begin
                if (scan_num != 2'd2) scan_num = scan_num + 2'd1;
                scan_code = {col_q, 2'(r)};
            end
        end
    end

    assign sample     = (dwell_q == DW'(DWELL - 1));
    assign frame_end  = sample && (col_q == 2'd3);
    assign is_single  = frame_end && (scan_num == 2'd1);
    assign match_held = is_single && (scan_code == key_code_q);
    assign match_cand = is_single && (scan_code == cand_q);

`ifdef KEY_REPEAT_EN
    localparam int RW = $clog2(REPEAT_SCANS + 1);
    logic [RW-1:0] rep_q, rep_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= 4'd0;
            key_code_q  <= 4'd0;
            key_held_q  <= 1'b0;
            key_valid_q <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
            key_valid_q <= key_valid_d;
`ifdef KEY_REPEAT_EN
            rep_q       <= rep_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        key_valid_d = 1'b0;
`ifdef KEY_REPEAT_EN
        rep_d       = rep_q;
`endif
        if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (is_single) begin
                        cand_d = scan_code;
                        cnt_d  = CW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d     = PRESSED;
                            key_code_d  = scan_code;
                            key_held_d  = 1'b1;
                            key_valid_d = 1'b1;
`ifdef KEY_REPEAT_EN
                            rep_d       = '0;
`endif
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (match_cand) begin
                        if (cnt_q != CW'(DEBOUNCE_SCANS)) cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CW'(DEBOUNCE_SCANS - 1)) begin
                            state_d     = PRESSED;
                            key_code_d  = cand_q;
                            key_held_d  = 1'b1;
                            key_valid_d = 1'b1;
`ifdef KEY_REPEAT_EN
                            rep_d       = '0;
`endif
                        end
                    end else if (is_single) begin
                        cand_d = scan_code;
                        cnt_d  = CW'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
                PRESSED: begin
                    if (match_held) begin
`ifdef KEY_REPEAT_EN
                        if (rep_q == RW'(REPEAT_SCANS - 1)) begin
                            rep_d       = '0;
                            key_valid_d = 1'b1;
                        end else begin
                            rep_d = rep_q + RW'(1);
                        end
`endif
                    end else if (DEBOUNCE_SCANS == 1) begin
                        state_d    = IDLE;
                        key_held_d = 1'b0;
                    end else begin
                        state_d = RELEASE;
                        cnt_d   = CW'(1);
                    end
                end
                RELEASE: begin
                    if (match_held) begin
                        state_d = PRESSED;
`ifdef KEY_REPEAT_EN
                        rep_d   = '0;
`endif
                    end else begin
                        if (cnt_q != CW'(DEBOUNCE_SCANS)) cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CW'(DEBOUNCE_SCANS - 1)) begin
                            state_d    = IDLE;
                            key_held_d = 1'b0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign col_sel   = ~(4'b0001 << col_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule
